// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder with valid/ready handshakes on both sides.
// One full-adder cell (two half adders plus an OR) is stepped LSB-first
// across the operands, one bit per clock, and the carry is held in a register.
module serial_adder_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [N-1:0]       a_sr;
  logic [N-1:0]       b_sr;
  logic [N-1:0]       sum_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               ha0_s;
  logic               ha0_c;
  logic               ha1_c;
  logic               fa_s;
  logic               fa_c;
  logic [N-1:0]       sum_next;

  // Full-adder cell: first half adder on the operand bits, second on the carry, OR of the two carries.
  assign ha0_s    = a_sr[0] ^ b_sr[0];
  assign ha0_c    = a_sr[0] & b_sr[0];
  assign fa_s     = ha0_s ^ carry;
  assign ha1_c    = ha0_s & carry;
  assign fa_c     = ha0_c | ha1_c;
  assign sum_next = {fa_s, sum_sr[N-1:1]};

  // Control FSM and datapath; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_c;
          if (cnt == CNT_W'(N - 1)) begin
            // Old carry register is the carry into the MSB; compare it with the MSB carry-out.
            sum       <= sum_next;
            cout      <= fa_c;
            ovf       <= carry ^ fa_c;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8) with an expected-result queue.
module tb_serial_adder_ctrl;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  serial_adder_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    logic [N:0] full;
    res_t       r;
    full   = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    r.sum  = full[N-1:0];
    r.cout = full[N];
    r.ovf  = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
    return r;
  endfunction

  // Waits (bounded) for in_ready, presents one operand set for one edge, records the expectation.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    a = x; b = y; cin = ci; in_valid = 1'b1;
    exp_q.push_back(model(x, y, ci));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 0 00 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int   cyc = 0;
    logic bad_ready = 1'b0;
    logic bad_busy = 1'b0;
    res_t e;
    out_ready = 1'b1;
    send(8'h3C, 8'h0F, 1'b0);
    while (!out_valid && cyc < 50) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (busy !== 1'b1) bad_busy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL basic_latency: out_valid after %0d cycles, expected %0d", cyc, N);
    end
    checks++;
    if (bad_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_in_ready: in_ready seen high during RUN/DONE, expected 0");
    end
    checks++;
    if (bad_busy !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy seen low during RUN/DONE, expected 1");
    end
    e = exp_q.pop_front();
    checks++;
    if ({sum, cout, ovf} !== {8'h4B, 1'b0, 1'b0} || {sum, cout, ovf} !== e) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b ovf=%b, expected sum=4b cout=0 ovf=0", sum, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_carry();
    logic [N-1:0] ta[2] = '{8'hFF, 8'hFF};
    logic [N-1:0] tb[2] = '{8'h01, 8'h00};
    logic         tc[2] = '{1'b0, 1'b1};
    int           cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], tc[i]);
      wait_valid(cyc);
      void'(exp_q.pop_front());
      checks++;
      if (cyc >= 50 || {sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL carry_%0d: valid=%b sum=%h cout=%b ovf=%b, expected sum=00 cout=1 ovf=0",
                 i, out_valid, sum, cout, ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] ta[2] = '{8'h7F, 8'h80};
    logic [N-1:0] tb[2] = '{8'h01, 8'h80};
    res_t         te[2] = '{{8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1}};
    int           cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], 1'b0);
      wait_valid(cyc);
      void'(exp_q.pop_front());
      checks++;
      if (cyc >= 50 || {sum, cout, ovf} !== te[i]) begin
        errors++;
        $display("FAIL overflow_%0d: valid=%b sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                 i, out_valid, sum, cout, ovf, te[i].sum, te[i].cout, te[i].ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int   cyc;
    res_t e;
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc >= 50 || {sum, cout, ovf} !== {8'h47, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_result: valid=%b sum=%h cout=%b ovf=%b, expected sum=47 cout=0 ovf=0",
               out_valid, sum, cout, ovf);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = N'($urandom);
      b = N'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b, expected 1 0 %h %b %b",
                 i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy, sum} !== {1'b0, 1'b1, 1'b0, e.sum}) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b sum=%h, expected 0 1 0 %h",
               out_valid, in_ready, busy, sum, e.sum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_capture: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    out_ready = 1'b1;
    send(8'h55, 8'hAA, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({out_valid, busy, sum, cout, ovf, in_ready} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b busy=%b sum=%h cout=%b ovf=%b in_ready=%b, expected 0 0 00 0 0 1",
               out_valid, busy, sum, cout, ovf, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    send(8'h01, 8'h01, 1'b0);
    wait_valid(cyc);
    void'(exp_q.pop_front());
    checks++;
    if (cyc >= 50 || {sum, cout, ovf} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fresh_add: valid=%b sum=%h cout=%b ovf=%b, expected sum=02 cout=0 ovf=0",
               out_valid, sum, cout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    int   accepted = 0;
    int   results = 0;
    int   cyc = 0;
    int   last = -1;
    res_t e;
    out_ready = 1'b1;
    while (results < 200 && cyc < 2600) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_unexpected: result with empty queue, sum=%h", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("FAIL stream_result_%0d: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     results, sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== N + 2) begin
            errors++;
            $display("FAIL stream_interval_%0d: %0d cycles between results, expected %0d",
                     results, cyc - last, N + 2);
          end
        end
        last = cyc;
        results++;
      end
      if (in_ready) begin
        if (accepted < 200) begin
          a = N'($urandom);
          b = N'($urandom);
          cin = 1'($urandom);
          in_valid = 1'b1;
          exp_q.push_back(model(a, b, cin));
          accepted++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (results !== 200 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stream_count: results=%0d pending=%0d, expected 200 and 0", results, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_streaming();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It accepts two N-bit operands plus carry-in over a valid/ready handshake. It then steps a single full-adder cell, built from two half-adder cells and an OR, across the operands LSB-first, one bit per clock, and holds the carry in a register between bits. It presents the registered sum, carry-out and signed-overflow flag on an output valid/ready handshake. It is the area-minimal alternative to the ripple N-bit adder and is used where throughput of one add per N+2 cycles is enough.

Parameters:
N, 8, operand/sum width in bits; legal range N >= 2
CNT_W, $clog2(N), bit-counter width (derived; not to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  operand A, unsigned or two's complement
b  input  N  operand B
cin  input  1  carry-in
out_valid  output  1  sum, cout, ovf valid
out_ready  input  1  consumer accepts result
sum  output  N  registered sum
cout  output  1  registered carry-out of bit N-1
ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Shift registers, carry register, bit counter, sum, cout and ovf all clear to 0.
  - out_valid=0, busy=0, in_ready=1.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a into shift register A and b into shift register B; carry register <= cin; counter <= 0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - Each edge computes s = A[0]^B[0]^carry and c = majority(A[0],B[0],carry) through the two half-adder cells plus OR.
  - s is shifted into the sum shift register from the MSB side. A and B shift right by one. carry <= c.
  - Counter increments each edge.
  - On the edge where counter == N-1, carry_prev is captured: the carry value entering bit N-1, i.e. the old carry register.
  - On that same edge, transfer the completed sum to the sum output, c to cout, (carry_prev ^ c) to ovf, and go to DONE.
  - in_ready=0 and in_valid is ignored throughout RUN.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable until the handshake.
  - On an edge with out_ready=1: go to IDLE; out_valid=0.
  - in_ready stays 0 in DONE. There is no same-edge accept of new operands.
- Latency: acceptance edge E0; RUN occupies E1..EN; out_valid is high after EN, i.e. N cycles after acceptance.
- Throughput: with out_ready tied high and in_valid held high, one add is accepted every N+2 cycles.
- sum, cout and ovf keep their last result after the output handshake, until the next result overwrites them at the final RUN edge. They are never partially updated.
- Arithmetic:
  - {cout,sum} = a + b + cin, exactly N+1 bits; no saturation.
  - ovf is meaningful for a two's-complement interpretation only.
- Operands are captured at acceptance. Changes on a, b or cin after E0 have no effect on the current add.
- Reset mid-RUN or mid-DONE aborts the operation with no output handshake. The block is back in IDLE with in_ready=1 on the first edge after rst_n deasserts.
- The counter never exceeds N-1. No wrap occurs in RUN, because leaving RUN is forced at N-1.
- No X propagation: every register has a reset value.

Test Plan:
- Basic add: N=8, a=0x3C, b=0x0F, cin=0, out_ready=1 → out_valid rises exactly 8 cycles after the accept edge; sum=0x4B, cout=0, ovf=0; in_ready=0 throughout RUN/DONE.
- Carry wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0.
  - Repeat with a=0xFF, b=0x00, cin=1 → same result.
- Signed overflow: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Backpressure: complete an add with out_ready=0 for 5 cycles, toggling in_valid, a and b meanwhile → out_valid, sum, cout and ovf are stable for all 5 cycles and no new operands are captured. Raise out_ready → IDLE on the next edge, in_ready=1.
- Reset mid-operation: accept 0x55+0xAA, assert rst_n low after 4 RUN cycles → out_valid, busy, sum, cout and ovf are all 0 immediately (asynchronous). After release, in_ready=1 and a fresh 0x01+0x01 gives sum=0x02.
- Streaming: in_valid and out_ready held high with random operands for 200 adds → one result every 10 cycles (N+2). Every result matches the reference model a+b+cin, with ovf checked against sign bits.
